// File: rtl/mux_bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit word in, one bit per accepted beat out, LSB first, down_last marks final beat.
// Latency 1 cycle from up handshake to first bit; up_ready only in IDLE or on an accepted last beat (no bubbles).
// Backpressure: down_bit/down_last/counter hold while down_valid && !down_ready. Optional: SERIALIZER_PARITY_EN.
module mux_bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_bit,
    output logic             down_last
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int TREE = 1 << CNT_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("mux_bit_serializer: WIDTH must be in 2..64");
        end
    endgenerate

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [NBITS-1:0] hold;
    logic [NBITS-1:0] load_word;
    logic [TREE-1:0]  tree_in;
    logic             in_shift;
    logic             at_last;
    logic             beat;
    logic             load;

    // Parity is folded into the holding register at load so the mux tree serves it like any data bit.
`ifdef SERIALIZER_PARITY_EN
    assign load_word = {^up_data, up_data};
`else
    assign load_word = up_data;
`endif

    assign in_shift = (state == SHIFT);
    assign at_last  = in_shift && (cnt == LAST_IDX);
    assign beat     = in_shift && down_ready;
    assign up_ready = !in_shift || (at_last && down_ready);
    assign load     = up_valid && up_ready;

    // Zero-padded to a power of two so the counter indexes the tree without range gaps.
    assign tree_in    = TREE'(hold);
    assign down_valid = in_shift;
    assign down_last  = at_last;
    assign down_bit   = in_shift && tree_in[cnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else if (load) begin
            hold  <= load_word;
            cnt   <= '0;
            state <= SHIFT;
        end else if (beat) begin
            if (at_last) begin
                state <= IDLE;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_bit_serializer.sv
// Bench for mux_bit_serializer (WIDTH=8): table of words with hand-derived serial sequences,
// scoreboard of expected beats, plus reset sequences.
module tb_mux_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic       down_valid;
    logic       down_ready;
    logic       down_bit;
    logic       down_last;

    mux_bit_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_bit   (down_bit),
        .down_last  (down_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp_seq is written in time order: leftmost bit is the first one emitted.
    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_seq;
        logic       exp_par;
        int         rdy_mode;
    } vec_t;

    typedef struct {
        logic b;
        logic last;
    } beat_t;

    vec_t  vecs[9];
    beat_t sbq[$];
    int    wq[$];
    int    rdy_mode;
    int    cyc;
    int    n_chk;
    int    n_fail;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx);
        beat_t e;
        for (int i = 0; i < 8; i++) begin
            e.b    = vecs[idx].exp_seq[7-i];
            e.last = (i == 7) && !PAR;
            sbq.push_back(e);
        end
        if (PAR) begin
            e.b    = vecs[idx].exp_par;
            e.last = 1'b1;
            sbq.push_back(e);
        end
    endtask

    task automatic step();
        beat_t e;
        @(negedge clk);
        down_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        if (wq.size() > 0) begin
            up_valid = 1'b1;
            up_data  = vecs[wq[0]].data;
        end else begin
            up_valid = 1'b0;
            up_data  = 8'($urandom);
        end
        #1;
        check("down_valid", down_valid, sbq.size() > 0);
        if (down_valid && sbq.size() > 0) begin
            check("up_ready_shift", up_ready, sbq[0].last && down_ready);
            if (down_ready) begin
                e = sbq.pop_front();
                check("down_bit", down_bit, e.b);
                check("down_last", down_last, e.last);
            end else begin
                check("stall_bit", down_bit, sbq[0].b);
                check("stall_last", down_last, sbq[0].last);
            end
        end else if (!down_valid) begin
            check("up_ready_idle", up_ready, 1'b1);
        end
        if (up_valid && up_ready) begin
            push_exp(wq[0]);
            void'(wq.pop_front());
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((wq.size() > 0 || sbq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (wq.size() > 0 || sbq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words and %0d beats still pending", wq.size(), sbq.size());
            wq.delete();
            sbq.delete();
        end
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_up_ready"}, up_ready, 1'b1);
        check({tag, "_down_valid"}, down_valid, 1'b0);
        check({tag, "_down_bit"}, down_bit, 1'b0);
        check({tag, "_down_last"}, down_last, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_chk    = 0;
        n_fail   = 0;
        cyc      = 0;
        rdy_mode = 0;

        vecs[0] = '{8'hA5, 8'b10100101, 1'b0, 0};
        vecs[1] = '{8'h0F, 8'b11110000, 1'b0, 0};
        vecs[2] = '{8'hF0, 8'b00001111, 1'b0, 0};
        vecs[3] = '{8'h3C, 8'b00111100, 1'b0, 1};
        vecs[4] = '{8'h07, 8'b11100000, 1'b1, 0};
        vecs[5] = '{8'h03, 8'b11000000, 1'b0, 1};
        vecs[6] = '{8'hC1, 8'b10000011, 1'b1, 1};
        vecs[7] = '{8'hFF, 8'b11111111, 1'b0, 0};
        vecs[8] = '{8'h01, 8'b10000000, 1'b1, 0};

        up_valid   = 1'b0;
        up_data    = 8'h00;
        down_ready = 1'b0;
        rst_n      = 1'b1;

        // Reset asserted between clock edges must clear outputs without a clock.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Each word on its own, with its own downstream ready pattern.
        for (int i = 0; i < 9; i++) begin
            rdy_mode = vecs[i].rdy_mode;
            wq.push_back(i);
            drain(60);
        end

        // Back-to-back 0F then F0: contiguous beats, ready only on last beats.
        rdy_mode = 0;
        wq.push_back(1);
        wq.push_back(2);
        drain(60);

        // Whole table streamed with backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 9; i++) wq.push_back(i);
        drain(400);

        // Reset after three bits of FF; no remnant may appear after release.
        rdy_mode = 0;
        wq.push_back(7);
        n = 0;
        while (sbq.size() != (PAR ? 6 : 5) && n < 20) begin
            step();
            n++;
        end
        check("midword_reached", sbq.size() == (PAR ? 6 : 5), 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        sbq.delete();
        wq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        wq.push_back(8);
        drain(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
